// File: rtl/rcounter_monitor.sv
// rcounter_monitor: receive-side decoder and health monitor for a ring-counter bus.
// Decodes the hot-bit position of each sampled code, follows the expected rotation,
// locks onto a clean sequence, counts full revolutions while locked and reports
// sequence errors with a one-cycle pulse and a saturating error count.
module rcounter_monitor #(
    parameter int WIDTH    = 4,
    parameter int DIR      = 0,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8,
    localparam int IDX_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             in_clk,
    input  logic             in_clr,
    input  logic             in_en,
    input  logic [WIDTH-1:0] in_q,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid,
    output logic             o_lock,
    output logic             o_err,
    output logic [7:0]       o_err_cnt,
    output logic [REV_W-1:0] o_rev
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    logic [1:0]       state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [REV_W-1:0] rev_q, rev_d;

    logic             one_hot;
    logic [IDX_W-1:0] hot_idx;
    logic [WIDTH-1:0] expected;
    logic             match;
    logic             wrap_step;

    // Decode the sampled code: one-hot test, hot-bit index and the code the ring should show next
    always_comb begin
        one_hot = (in_q != '0) && ((in_q & (in_q - WIDTH'(1))) == '0);
        hot_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_q[i]) begin
                hot_idx = IDX_W'(i);
            end
        end
        if (DIR == 0) begin
            expected  = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
            wrap_step = prev_q[WIDTH-1];
        end else begin
            expected  = {prev_q[0], prev_q[WIDTH-1:1]};
            wrap_step = prev_q[0];
        end
        match = (in_q == expected);
    end

    // Sequence tracking: search for a one-hot code, count legal steps to lock, watch for errors
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        prev_d    = prev_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        lock_d    = lock_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        rev_d     = rev_q;

        if (in_en) begin
            if (one_hot) begin
                valid_d = 1'b1;
                idx_d   = hot_idx;
            end else begin
                valid_d = 1'b0;
            end

            case (state_q)
                ST_SEARCH: begin
                    if (one_hot) begin
                        state_d = ST_TRACK;
                        prev_d  = in_q;
                        step_d  = 4'd0;
                    end
                end
                ST_TRACK: begin
                    if (match) begin
                        prev_d = in_q;
                        step_d = step_q + 4'd1;
                        if (step_q + 4'd1 == LOCK_TGT) begin
                            state_d = ST_LOCKED;
                            lock_d  = 1'b1;
                        end
                    end else if (one_hot) begin
                        prev_d = in_q;
                        step_d = 4'd0;
                    end else begin
                        state_d = ST_SEARCH;
                        step_d  = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        prev_d = in_q;
                        if (wrap_step) begin
                            rev_d = rev_q + REV_W'(1);
                        end
                    end else begin
                        err_d  = 1'b1;
                        lock_d = 1'b0;
                        step_d = 4'd0;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        if (one_hot) begin
                            state_d = ST_TRACK;
                            prev_d  = in_q;
                        end else begin
                            state_d = ST_SEARCH;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    step_d  = 4'd0;
                    lock_d  = 1'b0;
                end
            endcase
        end
    end

    // Register all state and outputs; clear has priority over enable
    always_ff @(posedge in_clk) begin
        if (in_clr) begin
            state_q   <= ST_SEARCH;
            step_q    <= 4'd0;
            prev_q    <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            lock_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            rev_q     <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            prev_q    <= prev_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            lock_q    <= lock_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            rev_q     <= rev_d;
        end
    end

    assign o_idx     = idx_q;
    assign o_valid   = valid_q;
    assign o_lock    = lock_q;
    assign o_err     = err_q;
    assign o_err_cnt = err_cnt_q;
    assign o_rev     = rev_q;

endmodule
